// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_WIDTH  = 4;

  // Flags misaligned byte addresses and any address beyond the stored words.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Synchronous single-port word RAM with per-byte write enables and registered read data.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory responder with programmable wait states and a one-cycle response.
// Optional byte-strobe stores are enabled by defining MEM_BYTE_STROBE_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]            req_be,
`endif
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  state_t                  state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    write_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [WORD_BYTES-1:0]   be_q;

  logic                    req_err;
  logic [WORD_BYTES-1:0]   req_be_i;
  logic                    enter_resp;
  logic                    cur_write;
  logic                    cur_err;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [WORD_BYTES-1:0]   cur_be;
  logic                    arr_we;
  logic [DATA_WIDTH-1:0]   arr_rdata;

`ifdef MEM_BYTE_STROBE_EN
  assign req_be_i = req_be;
`else
  assign req_be_i = '1;
`endif

  assign req_ready = (state == IDLE) && !rst;
  assign req_err   = addr_err(req_addr, ADDR_WIDTH);

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // array must see the live request rather than the not-yet-captured copy.
  always_comb begin
    enter_resp = 1'b0;
    cur_write  = write_q;
    cur_err    = err_q;
    cur_idx    = idx_q;
    cur_wdata  = wdata_q;
    cur_be     = be_q;
    if (state == IDLE) begin
      cur_write  = req_write;
      cur_err    = req_err;
      cur_idx    = req_addr[ADDR_WIDTH+1:2];
      cur_wdata  = req_wdata;
      cur_be     = req_be_i;
      enter_resp = req_valid && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == '0);
    end
    if (rst) enter_resp = 1'b0;
  end

  assign arr_we = enter_resp && cur_write && !cur_err;

  mem_resp_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (cur_be),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      resp_valid <= (state == RESP);
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            err_q   <= req_err;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be_i;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_WIDTH'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          resp_rdata <= (write_q || err_q) ? '0 : arr_rdata;
          resp_err   <= err_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, response scoreboard, corner-case sequences.
module tb_mem_responder;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        req_valid0 = 1'b0;
  logic        req_ready0;
  logic [3:0]  req_be0 = 4'hF;
  logic        resp_valid0;
  logic [31:0] resp_rdata0;
  logic        resp_err0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(1'b1), .req_addr(32'h8), .req_wdata(32'h0000_1234),
`ifdef MEM_BYTE_STROBE_EN
    .req_be(req_be0),
`endif
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } sb_t;

  sb_t  exp_q[$];
  sb_t  e_mon;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e_mon.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e_mon.err});
        check("resp_cycle", cyc, e_mon.due);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int unsigned n;
    int unsigned low;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err, due: cyc + W + 2});
    @(posedge clk);
    #1 req_valid = 1'b0;
    low = 0;
    @(negedge clk);
    while (!req_ready && low < 50) begin
      low++;
      @(negedge clk);
    end
    check("ready_low_cycles", low, W + 1);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int unsigned pulses;
    int unsigned acc0;
    int unsigned pulses0;
    int unsigned double0;
    logic        prev0;

    vecs[0] = '{1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h10,  32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h13,  32'h0,         4'hF, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h400, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 32'h12,  32'h1234_5678, 4'hF, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h10,  32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[6] = '{1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 32'h3FC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[8] = '{1'b1, 32'h20,  32'h0BAD_F00D, 4'hF, 32'h0,         1'b0};
    vecs[9] = '{1'b0, 32'h20,  32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    check("idle_valid", {31'd0, resp_valid}, 32'd0);
    check("idle_rdata", resp_rdata, 32'd0);
    check("idle_err", {31'd0, resp_err}, 32'd0);

    for (int i = 0; i < 10; i++)
      do_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err);

    // Outputs hold after the response pulse.
    repeat (3) @(negedge clk);
    check("rdata_hold", resp_rdata, 32'h0BAD_F00D);

    // Reset during WAIT drops the store and emits no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h5555_5555;
    check("abort_accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_resp", pulses, 32'd0);
    check("abort_rdata_reset", resp_rdata, 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);

`ifdef MEM_BYTE_STROBE_EN
    do_req(1'b1, 32'h40, 32'hAAAA_AAAA, 4'hF,    32'h0, 1'b0);
    do_req(1'b1, 32'h40, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
    do_req(1'b0, 32'h40, 32'h0,         4'h0,    32'hAA22_AA44, 1'b0);
    do_req(1'b1, 32'h40, 32'h0,         4'h0,    32'h0, 1'b0);
    do_req(1'b0, 32'h40, 32'h0,         4'h0,    32'hAA22_AA44, 1'b0);
`endif

    // Zero wait states with req_valid held high: acceptance every other cycle.
    @(negedge clk);
    req_valid0 = 1'b1;
    acc0 = 0;
    pulses0 = 0;
    double0 = 0;
    prev0 = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_valid0 && req_ready0) acc0++;
      if (resp_valid0) begin
        pulses0++;
        if (prev0) double0++;
        if (resp_err0 || resp_rdata0 != 32'd0) double0++;
      end
      prev0 = resp_valid0;
      @(negedge clk);
      #1;
    end
    req_valid0 = 1'b0;
    repeat (4) begin
      if (resp_valid0) begin
        pulses0++;
        if (prev0) double0++;
      end
      prev0 = resp_valid0;
      @(negedge clk);
      #1;
    end
    check("w0_acceptances", acc0, 32'd10);
    check("w0_pulses", pulses0, 32'd10);
    check("w0_single_pulse", double0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual %0d required %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU data-memory interface: accepts one load or store request per transaction over a valid/ready handshake, applies a programmable wait-state delay, and returns a single-cycle response.
- Replaces the zero-latency data memory when the core is extended to stall on memory, and is used standalone to model slow memory in benches.
- Word-organised storage; byte addresses arrive from the ALU result path.

Parameters:
- ADDR_WIDTH, 8, log2 of the number of 32-bit words stored (256 words).
- DATA_WIDTH, 32, data word width; fixed at 32 for the CPU, and other values are not supported.
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 to 15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response pulse, exactly one cycle.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset: synchronous, active-high.
  - state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - req_ready = 0 while rst is high.
  - Storage array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at edge T0: capture write, addr, wdata; evaluate error.
  - If WAIT_CYCLES > 0, go to WAIT with counter = WAIT_CYCLES - 1; otherwise go to RESP.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - When counter == 0, go to RESP.
- RESP:
  - resp_valid = 1 for exactly this one cycle; no backpressure.
  - Return to IDLE on the next edge.
- Latency: resp_valid is high in the cycle following edge T0 + WAIT_CYCLES + 1.
  - Minimum spacing between acceptances is WAIT_CYCLES + 2 cycles.
- Error condition: req_addr[1:0] != 0, or req_addr[31:ADDR_WIDTH+2] != 0.
  - No array access occurs and no store is committed.
  - resp_err = 1 and resp_rdata = 0.
- Store commit: the array write occurs on the edge entering RESP.
  - resp_rdata = 0 for stores; resp_err = 0 unless the error condition holds.
- Load: the array is read on the edge entering RESP; resp_rdata holds the word at addr[ADDR_WIDTH+1:2].
- A store followed immediately by a load to the same address returns the new data, because the commit precedes the next acceptance.
- Registered outputs: resp_rdata and resp_err hold their values until the next RESP or reset. resp_valid is registered.
- req_valid outside IDLE is ignored; no request is queued.
- Reset in WAIT or RESP aborts the transaction: no response is issued, and a store not yet committed is dropped.

Optional Feature:
- Macro: MEM_BYTE_STROBE_EN.
- Defined:
  - Adds input port req_be [3:0].
  - A store writes only the byte lanes whose bits are set; lane i = bits 8i+7:8i.
  - req_be = 0 commits nothing but still responds.
  - Loads ignore req_be.
- Undefined: no req_be port; every store writes the full word.

Decomposition:
- Package mem_resp_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - WORD_BYTES = 4.
  - Wait-counter width constant = 4.
  - Error-check helper function.
- Sub-module mem_resp_array: synchronous single-port word RAM with write enable and optional per-byte enables; read data registered.
- FSM, wait counter and error logic stay in mem_responder.

Test Plan:
- Reset, then an idle cycle -> req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Store 0xDEADBEEF to 0x10, then load 0x10, WAIT_CYCLES = 2 -> store response with rdata 0 four cycles after its acceptance; load response with rdata 0xDEADBEEF; req_ready low for 3 cycles per transaction.
- Load 0x13 and load 0x400 (ADDR_WIDTH = 8) -> resp_err = 1, rdata = 0, array unchanged on readback.
- req_valid held high continuously with WAIT_CYCLES = 0 -> one acceptance every 2 cycles; resp_valid is a single-cycle pulse.
- Reset asserted during WAIT of a store to 0x20 -> no resp_valid; subsequent load of 0x20 returns the prior value.
- With MEM_BYTE_STROBE_EN: store 0x11223344 with be = 4'b0101 over 0xAAAAAAAA, then load -> 0xAA22AA44.
